// File: rtl/histogram_cdf_hesaplama_pkg.sv
// Shared constants and state encoding for the histogram/CDF stage.
package histogram_cdf_hesaplama_pkg;

  localparam int PIKSEL_W   = 8;
  localparam int BIN_SAYISI = 256;
  localparam int CDF_W      = 18;
  // One extra bit so the bin counter can reach BIN_SAYISI (the CDF drain step).
  localparam int ADRES_W    = $clog2(BIN_SAYISI) + 1;

  typedef enum logic [2:0] {
    BOSTA   = 3'd0,
    TEMIZLE = 3'd1,
    TOPLA   = 3'd2,
    CDF     = 3'd3,
    SORGU   = 3'd4
  } durum_t;

endpackage

// File: rtl/histogram_cdf_hesaplama_bellek.sv
// 256x18 simple dual-port histogram RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old contents.
module histogram_bellek
  import histogram_cdf_hesaplama_pkg::*;
(
  input  logic                clk,
  input  logic                yaz_etkin,
  input  logic [PIKSEL_W-1:0] yaz_adres,
  input  logic [CDF_W-1:0]    yaz_veri,
  input  logic [PIKSEL_W-1:0] oku_adres,
  output logic [CDF_W-1:0]    oku_veri
);

  logic [CDF_W-1:0] mem [BIN_SAYISI];

  // Write port and 1-cycle synchronous read port; read-old falls out of the NBA ordering.
  // NOTE: the array has no reset so the tools can map it onto block RAM; the clear pass rewrites it.
  always_ff @(posedge clk) begin
    if (yaz_etkin) begin
      mem[yaz_adres] <= yaz_veri;
    end
    oku_veri <= mem[oku_adres];
  end

endmodule

// File: rtl/histogram_cdf_hesaplama.sv
// Histogram -> in-place CDF -> per-pixel lookup stage feeding histogram_esitleme.
// Pass 1 counts pixels into 256 bins, the bins are then accumulated into a CDF,
// and pass 2 returns CDF[pixel] and cdf_min two cycles after each lookup pixel.
module histogram_cdf_hesaplama
  import histogram_cdf_hesaplama_pkg::*;
#(
  parameter int M = 320,
  parameter int N = 240
)
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        baslat_i,
  input  logic        etkin_i,
  input  logic [7:0]  pixel_i,
  input  logic        sorgu_etkin_i,
  input  logic [7:0]  sorgu_pixel_i,
  output logic        hazir_o,
  output logic [2:0]  durum_o,
  output logic        etkin_o,
  output logic [7:0]  pixel_o,
  output logic [17:0] cdf_o,
  output logic [17:0] cdf_min_o
);

  localparam logic [CDF_W-1:0]   MN        = CDF_W'(M * N);
  localparam logic [ADRES_W-1:0] SON_BIN   = ADRES_W'(BIN_SAYISI - 1);
  localparam logic [ADRES_W-1:0] CDF_BITIS = ADRES_W'(BIN_SAYISI);

  durum_t durum, durum_sonraki;

  logic [ADRES_W-1:0]  adres_sayac;   // bin index for the clear and CDF passes
  logic [CDF_W-1:0]    piksel_sayac;  // accepted pixels (count pass) or lookups (lookup pass)
  logic                bosalt;        // drain cycle after the last counted pixel

  // Stage-1 register shared by all passes: "a read was issued last cycle for this bin".
  logic                s1_gecerli, s1_sonraki;
  logic [PIKSEL_W-1:0] s1_adres;

  // Copy of last cycle's RAM write, used to bypass the read-old RAM output.
  logic                son_gecerli;
  logic [PIKSEL_W-1:0] son_adres;
  logic [CDF_W-1:0]    son_veri;

  logic [CDF_W-1:0]    toplam, toplam_yeni, cdf_min, eski_sayim;
  logic                min_bulundu;
  logic                kabul_topla, kabul_sorgu;

  logic                ram_yaz;
  logic [PIKSEL_W-1:0] ram_yaz_adres, ram_oku_adres;
  logic [CDF_W-1:0]    ram_yaz_veri, ram_oku_veri;

  histogram_bellek u_bellek (
    .clk       (clk_i),
    .yaz_etkin (ram_yaz),
    .yaz_adres (ram_yaz_adres),
    .yaz_veri  (ram_yaz_veri),
    .oku_adres (ram_oku_adres),
    .oku_veri  (ram_oku_veri)
  );

  assign kabul_topla = (durum == TOPLA) && !bosalt && etkin_i;
  assign kabul_sorgu = (durum == SORGU) && (piksel_sayac != MN) && sorgu_etkin_i;
  assign hazir_o     = ((durum == TOPLA) && !bosalt) || ((durum == SORGU) && (piksel_sayac != MN));

  // Back-to-back hits on one bin: the RAM still returns the pre-write count, so take the
  // value written last cycle instead.
  assign eski_sayim  = (son_gecerli && (son_adres == s1_adres)) ? son_veri : ram_oku_veri;
  assign toplam_yeni = toplam + ram_oku_veri;

  assign durum_o   = durum;
  assign cdf_min_o = cdf_min;

  // State register.
  // NOTE: clocked blocks use non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum <= BOSTA;
    end else begin
      durum <= durum_sonraki;
    end
  end

  // Next-state logic.
  // NOTE: the default is assigned before the case so no path leaves the output unassigned (no latch).
  always_comb begin
    durum_sonraki = durum;
    case (durum)
      BOSTA:   if (baslat_i) durum_sonraki = TEMIZLE;
      TEMIZLE: if (adres_sayac == SON_BIN) durum_sonraki = TOPLA;
      TOPLA:   if (bosalt) durum_sonraki = CDF;
      CDF:     if (adres_sayac == CDF_BITIS) durum_sonraki = SORGU;
      SORGU:   if ((piksel_sayac == MN) && !s1_gecerli) durum_sonraki = BOSTA;
      default: durum_sonraki = BOSTA;
    endcase
  end

  // RAM port steering and stage-1 launch for the current pass.
  always_comb begin
    ram_yaz       = 1'b0;
    ram_yaz_adres = s1_adres;
    ram_yaz_veri  = '0;
    ram_oku_adres = '0;
    s1_sonraki    = 1'b0;
    case (durum)
      TEMIZLE: begin
        ram_yaz       = 1'b1;
        ram_yaz_adres = adres_sayac[PIKSEL_W-1:0];
      end
      TOPLA: begin
        ram_oku_adres = pixel_i;
        s1_sonraki    = kabul_topla;
        ram_yaz       = s1_gecerli;
        ram_yaz_veri  = eski_sayim + CDF_W'(1);
      end
      CDF: begin
        ram_oku_adres = adres_sayac[PIKSEL_W-1:0];
        s1_sonraki    = (adres_sayac != CDF_BITIS);
        ram_yaz       = s1_gecerli;
        ram_yaz_veri  = toplam_yeni;
      end
      SORGU: begin
        ram_oku_adres = sorgu_pixel_i;
        s1_sonraki    = kabul_sorgu;
      end
      default: ;
    endcase
  end

  // Stage-1 register and last-write bypass copy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_gecerli  <= 1'b0;
      s1_adres    <= '0;
      son_gecerli <= 1'b0;
      son_adres   <= '0;
      son_veri    <= '0;
    end else begin
      s1_gecerli  <= s1_sonraki;
      s1_adres    <= ram_oku_adres;
      son_gecerli <= ram_yaz;
      son_adres   <= ram_yaz_adres;
      son_veri    <= ram_yaz_veri;
    end
  end

  // Pass counters, drain flag, CDF accumulator and cdf_min capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adres_sayac  <= '0;
      piksel_sayac <= '0;
      bosalt       <= 1'b0;
      toplam       <= '0;
      cdf_min      <= '0;
      min_bulundu  <= 1'b0;
    end else begin
      case (durum)
        BOSTA: begin
          if (baslat_i) begin
            adres_sayac  <= '0;
            piksel_sayac <= '0;
            bosalt       <= 1'b0;
            toplam       <= '0;
            cdf_min      <= '0;
            min_bulundu  <= 1'b0;
          end
        end
        TEMIZLE: begin
          adres_sayac <= (adres_sayac == SON_BIN) ? '0 : adres_sayac + ADRES_W'(1);
        end
        TOPLA: begin
          if (bosalt) begin
            bosalt       <= 1'b0;
            piksel_sayac <= '0;
          end else if (kabul_topla) begin
            piksel_sayac <= piksel_sayac + CDF_W'(1);
            if (piksel_sayac == MN - CDF_W'(1)) begin
              bosalt <= 1'b1;
            end
          end
        end
        CDF: begin
          adres_sayac <= (adres_sayac == CDF_BITIS) ? '0 : adres_sayac + ADRES_W'(1);
          if (s1_gecerli) begin
            toplam <= toplam_yeni;
            if (!min_bulundu && (ram_oku_veri != '0)) begin
              cdf_min     <= toplam_yeni;
              min_bulundu <= 1'b1;
            end
          end
        end
        SORGU: begin
          if (kabul_sorgu) begin
            piksel_sayac <= piksel_sayac + CDF_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Lookup result register: lands two cycles after the lookup pixel was accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      etkin_o <= 1'b0;
      pixel_o <= '0;
      cdf_o   <= '0;
    end else begin
      etkin_o <= (durum == SORGU) && s1_gecerli;
      if ((durum == SORGU) && s1_gecerli) begin
        pixel_o <= s1_adres;
        cdf_o   <= ram_oku_veri;
      end
    end
  end

  // The last CDF entry must equal the frame size.
  always_ff @(posedge clk_i) begin
    if (!rst_i && (durum == CDF) && (adres_sayac == CDF_BITIS)) begin
      assert (toplam_yeni == MN);
    end
  end

endmodule

// File: tb/tb_histogram_cdf_hesaplama.sv
// Directed bench for histogram_cdf_hesaplama with a 4x4 frame.
module tb_histogram_cdf_hesaplama;
  import histogram_cdf_hesaplama_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        baslat_i = 1'b0;
  logic        etkin_i = 1'b0;
  logic [7:0]  pixel_i = '0;
  logic        sorgu_etkin_i = 1'b0;
  logic [7:0]  sorgu_pixel_i = '0;
  logic        hazir_o;
  logic [2:0]  durum_o;
  logic        etkin_o;
  logic [7:0]  pixel_o;
  logic [17:0] cdf_o;
  logic [17:0] cdf_min_o;

  int kontrol = 0;
  int hata = 0;

  int kare [16];
  int sorgu [16];
  int beklenen [16];

  histogram_cdf_hesaplama #(.M(4), .N(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .baslat_i      (baslat_i),
    .etkin_i       (etkin_i),
    .pixel_i       (pixel_i),
    .sorgu_etkin_i (sorgu_etkin_i),
    .sorgu_pixel_i (sorgu_pixel_i),
    .hazir_o       (hazir_o),
    .durum_o       (durum_o),
    .etkin_o       (etkin_o),
    .pixel_o       (pixel_o),
    .cdf_o         (cdf_o),
    .cdf_min_o     (cdf_min_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    kontrol++;
    assert (obs === exp) else begin
      hata++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic durum_bekle(input logic [2:0] hedef, input int butce, input string ad);
    int n = 0;
    while (durum_o !== hedef && n < butce) begin
      @(negedge clk);
      n++;
    end
    check(ad, 32'(durum_o), 32'(hedef));
  endtask

  // Counting pass: optional idle cycle before each pixel (with a stray baslat_i pulse),
  // optional etkin_i held high through the drain cycle.
  task automatic sayim_gecisi(input int pix [16], input bit aralikli, input bit bosaltma_gurultu,
                              input string ad);
    @(negedge clk);
    baslat_i = 1'b1;
    @(negedge clk);
    baslat_i = 1'b0;
    check({ad, "_temizle"}, 32'(durum_o), 32'(TEMIZLE));
    durum_bekle(TOPLA, 300, {ad, "_topla"});
    check({ad, "_hazir"}, 32'(hazir_o), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (aralikli) begin
        @(negedge clk);
        etkin_i  = 1'b0;
        baslat_i = (i == 5);
      end
      @(negedge clk);
      baslat_i = 1'b0;
      etkin_i  = 1'b1;
      pixel_i  = 8'(pix[i]);
    end
    @(negedge clk);
    etkin_i = bosaltma_gurultu;
    pixel_i = 8'(pix[0]);
    check({ad, "_bosalt_hazir"}, 32'(hazir_o), 32'd0);
    check({ad, "_bosalt_durum"}, 32'(durum_o), 32'(TOPLA));
    @(negedge clk);
    etkin_i = 1'b0;
    check({ad, "_cdf"}, 32'(durum_o), 32'(CDF));
    durum_bekle(SORGU, 300, {ad, "_sorgu"});
  endtask

  // Lookup pass: 16 back-to-back lookups, each result checked two cycles later.
  task automatic sorgu_gecisi(input int pix [16], input int bek [16], input int bek_min,
                              input string ad);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("%s_etkin_%0d", ad, i - 2), 32'(etkin_o), 32'd1);
        check($sformatf("%s_pixel_%0d", ad, i - 2), 32'(pixel_o), 32'(pix[i - 2]));
        check($sformatf("%s_cdf_%0d", ad, i - 2), 32'(cdf_o), 32'(bek[i - 2]));
        check($sformatf("%s_min_%0d", ad, i - 2), 32'(cdf_min_o), 32'(bek_min));
      end else begin
        check($sformatf("%s_bos_%0d", ad, i), 32'(etkin_o), 32'd0);
      end
      if (i < 16) begin
        sorgu_etkin_i = 1'b1;
        sorgu_pixel_i = 8'(pix[i]);
      end else begin
        sorgu_etkin_i = 1'b0;
      end
    end
    @(negedge clk);
    check({ad, "_son_etkin"}, 32'(etkin_o), 32'd0);
    check({ad, "_bosta"}, 32'(durum_o), 32'(BOSTA));
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    check("rst_durum", 32'(durum_o), 32'(BOSTA));
    check("rst_etkin", 32'(etkin_o), 32'd0);
    check("rst_cdf", 32'(cdf_o), 32'd0);
    check("rst_min", 32'(cdf_min_o), 32'd0);
    check("rst_hazir", 32'(hazir_o), 32'd0);

    // Ramp frame 0..15: CDF[p] = p+1, saturating at 16
    for (int i = 0; i < 16; i++) kare[i] = i;
    sayim_gecisi(kare, 1'b0, 1'b0, "rampa");
    sorgu    = '{7, 0, 15, 100, 255, 1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 12};
    beklenen = '{8, 1, 16, 16, 16, 2, 3, 4, 5, 6, 7, 9, 10, 11, 12, 13};
    sorgu_gecisi(sorgu, beklenen, 1, "rampa");

    // Sixteen copies of pixel 200: exercises the write-data bypass
    for (int i = 0; i < 16; i++) kare[i] = 200;
    sayim_gecisi(kare, 1'b0, 1'b0, "ayni");
    sorgu    = '{200, 199, 0, 201, 255, 200, 200, 100, 150, 210, 199, 200, 250, 1, 2, 200};
    beklenen = '{16, 0, 0, 16, 16, 16, 16, 0, 0, 16, 0, 16, 16, 0, 0, 16};
    sorgu_gecisi(sorgu, beklenen, 16, "ayni");

    // Reset in the middle of a counting pass aborts the frame
    check("iptal_oncesi_cdf", 32'(cdf_o), 32'd16);
    @(negedge clk);
    baslat_i = 1'b1;
    @(negedge clk);
    baslat_i = 1'b0;
    durum_bekle(TOPLA, 300, "iptal_topla");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      etkin_i = 1'b1;
      pixel_i = 8'd100;
    end
    @(negedge clk);
    etkin_i = 1'b0;
    rst_i   = 1'b1;
    @(negedge clk);
    check("iptal_durum", 32'(durum_o), 32'(BOSTA));
    check("iptal_etkin", 32'(etkin_o), 32'd0);
    check("iptal_cdf", 32'(cdf_o), 32'd0);
    check("iptal_min", 32'(cdf_min_o), 32'd0);
    rst_i = 1'b0;

    // Mixed 10/250 frame, etkin_i left high in the drain cycle
    kare     = '{10, 10, 250, 10, 250, 250, 10, 250, 10, 10, 250, 250, 10, 250, 10, 250};
    sayim_gecisi(kare, 1'b0, 1'b1, "karisik");
    sorgu    = '{10, 0, 9, 250, 11, 249, 255, 5, 10, 250, 100, 1, 10, 251, 3, 2};
    beklenen = '{8, 0, 0, 16, 8, 8, 16, 0, 8, 16, 8, 0, 8, 16, 0, 0};
    sorgu_gecisi(sorgu, beklenen, 8, "karisik");

    // Gapped handshake with a stray baslat_i pulse during counting
    kare     = '{3, 3, 3, 5, 5, 0, 0, 0, 0, 9, 9, 9, 9, 9, 3, 255};
    sayim_gecisi(kare, 1'b1, 1'b0, "aralik");
    sorgu    = '{0, 1, 3, 4, 5, 8, 9, 254, 255, 2, 3, 5, 9, 0, 255, 100};
    beklenen = '{4, 4, 8, 8, 10, 10, 15, 15, 16, 4, 8, 10, 15, 4, 16, 15};
    sorgu_gecisi(sorgu, beklenen, 4, "aralik");

    $display("CHECKS %0d ERRORS %0d", kontrol, hata);
    $finish;
  end

endmodule
